// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the 1-to-2 stream demultiplexer
package demux_pkg;
  localparam logic LANE_Y0 = 1'b0;
  localparam logic LANE_Y1 = 1'b1;
  localparam logic MODE_EXPLICIT = 1'b0;
  localparam logic MODE_ALT = 1'b1;
  localparam int DEF_WIDTH = 2;
  localparam int DEF_COUNT_W = 8;
endpackage

// File: rtl/demux_lane_slot.sv
// demux_lane_slot: one-entry output lane register with free flag and beat counter
import demux_pkg::*;
module demux_lane_slot #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fill,
  input  logic [WIDTH-1:0]   fill_data,
  input  logic               ready,
  output logic [WIDTH-1:0]   data,
  output logic               valid,
  output logic               free,
  output logic [COUNT_W-1:0] cnt
);
  assign free = !valid || ready;
  // fill takes priority so a drain and refill on the same edge leaves the slot full
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else if (fill) begin
      data  <= fill_data;
      valid <= 1'b1;
      cnt   <= cnt + 1'b1;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/demux_1x2_stream.sv
// demux_1x2_stream: registered 1-to-2 stream demux with explicit or alternating lane select
import demux_pkg::*;
module demux_1x2_stream #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               s,
  input  logic               mode,
  output logic [WIDTH-1:0]   y0_data,
  output logic               y0_valid,
  input  logic               y0_ready,
  output logic [WIDTH-1:0]   y1_data,
  output logic               y1_valid,
  input  logic               y1_ready,
  output logic [COUNT_W-1:0] cnt0,
  output logic [COUNT_W-1:0] cnt1
);
  logic ptr, tgt, free0, free1, acc;
  // target lane and acceptance; in_ready never depends on in_valid
  always_comb begin
    tgt = (mode == MODE_ALT) ? ptr : s;
    in_ready = !rst && ((tgt == LANE_Y1) ? free1 : free0);
    acc = in_valid && in_ready;
  end
  // alternating pointer advances only on beats accepted in alternate mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= LANE_Y0;
    else if (acc && mode == MODE_ALT) ptr <= !ptr;
  end
  demux_lane_slot #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) u_lane0 (
    .clk(clk), .rst(rst), .fill(acc && tgt == LANE_Y0), .fill_data(in_data),
    .ready(y0_ready), .data(y0_data), .valid(y0_valid), .free(free0), .cnt(cnt0)
  );
  demux_lane_slot #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) u_lane1 (
    .clk(clk), .rst(rst), .fill(acc && tgt == LANE_Y1), .fill_data(in_data),
    .ready(y1_ready), .data(y1_data), .valid(y1_valid), .free(free1), .cnt(cnt1)
  );
endmodule
